// File: rtl/stim_pkg.sv
// stim_pkg: shared definitions for the stimulus player.
//   - state_e     : player FSM states (ST_IDLE, ST_WAIT)
//   - *_DEF       : default field widths and FIFO depth
//   - stim_rec_t  : one timed record {dly, a, b} at the default widths
//   - rec_width() : packed record width for arbitrary field widths
package stim_pkg;

  localparam int A_WIDTH_DEF   = 17;
  localparam int B_WIDTH_DEF   = 5;
  localparam int DLY_WIDTH_DEF = 8;
  localparam int DEPTH_DEF     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [DLY_WIDTH_DEF-1:0] dly;
    logic [A_WIDTH_DEF-1:0]   a;
    logic [B_WIDTH_DEF-1:0]   b;
  } stim_rec_t;

  function automatic int rec_width(input int dly_w, input int a_w, input int b_w);
    return dly_w + a_w + b_w;
  endfunction

endpackage

// File: rtl/stim_fifo.sv
// stim_fifo: small synchronous FIFO holding packed stimulus records.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears pointers only)
//   push, wdata  : write request and data; ignored while full (no bypass)
//   pop          : read request; ignored while empty
//   full, empty  : occupancy flags derived from current pointers
//   head         : record at the read pointer, valid whenever !empty
module stim_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a full ring from an empty one.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full is evaluated before any same-edge pop, so a push into a full
  // FIFO is refused even when a slot is being freed on that edge.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/stim_player.sv
// stim_player: plays timed stimulus records {dly, a, b} onto DUT-facing
// registers. Each record waits dly cycles (counted only while run is high)
// after being loaded, then its a/b values are applied.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid/in_ready     : host record handshake (in_ready = !full)
//   in_dly, in_a, in_b    : record fields
//   run                   : playback enable; pushes accepted regardless
//   out_a, out_b          : registered stimulus, hold last applied value
//   out_stb               : one-cycle pulse after each apply
//   applied_count         : applies since reset, wraps at 2^16
//   idle                  : FSM idle and FIFO empty
module stim_player
  import stim_pkg::*;
#(
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int B_WIDTH   = B_WIDTH_DEF,
  parameter int DLY_WIDTH = DLY_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DLY_WIDTH-1:0] in_dly,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 run,
  output logic [A_WIDTH-1:0]   out_a,
  output logic [B_WIDTH-1:0]   out_b,
  output logic                 out_stb,
  output logic [15:0]          applied_count,
  output logic                 idle
);

  localparam int REC_W = rec_width(DLY_WIDTH, A_WIDTH, B_WIDTH);

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [REC_W-1:0] head;

  state_e                 state_q, state_d;
  logic [DLY_WIDTH-1:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0]     work_a_q, work_a_d;
  logic [B_WIDTH-1:0]     work_b_q, work_b_d;
  logic [A_WIDTH-1:0]     out_a_q, out_a_d;
  logic [B_WIDTH-1:0]     out_b_q, out_b_d;
  logic                   out_stb_q, out_stb_d;
  logic [15:0]            applied_count_q, applied_count_d;

  logic apply;
  logic load;

  stim_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (pop),
    .wdata   ({in_dly, in_a, in_b}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Apply when the working record's countdown has expired; the next record
  // is loaded on the same edge so dly=0 records play on consecutive cycles.
  assign apply = (state_q == ST_WAIT) && run && (cnt_q == '0);
  assign load  = run && !fifo_empty && ((state_q == ST_IDLE) || apply);
  assign pop   = load;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      work_a_q        <= '0;
      work_b_q        <= '0;
      out_a_q         <= '0;
      out_b_q         <= '0;
      out_stb_q       <= 1'b0;
      applied_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      work_a_q        <= work_a_d;
      work_b_q        <= work_b_d;
      out_a_q         <= out_a_d;
      out_b_q         <= out_b_d;
      out_stb_q       <= out_stb_d;
      applied_count_q <= applied_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_WAIT;
      ST_WAIT: if (apply && !load) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, working record and output register updates.
  always_comb begin
    cnt_d           = cnt_q;
    work_a_d        = work_a_q;
    work_b_d        = work_b_q;
    out_a_d         = out_a_q;
    out_b_d         = out_b_q;
    out_stb_d       = apply;
    applied_count_d = applied_count_q;

    if (apply) begin
      out_a_d         = work_a_q;
      out_b_d         = work_b_q;
      applied_count_d = applied_count_q + 16'd1;
    end

    if (load) begin
      cnt_d    = head[REC_W-1 -: DLY_WIDTH];
      work_a_d = head[A_WIDTH+B_WIDTH-1 -: A_WIDTH];
      work_b_d = head[B_WIDTH-1:0];
    end else if ((state_q == ST_WAIT) && run && (cnt_q != '0)) begin
      cnt_d = cnt_q - DLY_WIDTH'(1);
    end
  end

  assign out_a         = out_a_q;
  assign out_b         = out_b_q;
  assign out_stb       = out_stb_q;
  assign applied_count = applied_count_q;
  assign in_ready      = !fifo_full;
  assign idle          = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_stim_player.sv
// tb_stim_player: directed and randomized checks of stim_player against a
// reference model that schedules each record by an absolute due time
// measured in run-enabled clock edges.
module tb_stim_player;
  import stim_pkg::*;

  localparam int AW    = A_WIDTH_DEF;
  localparam int BW    = B_WIDTH_DEF;
  localparam int DW    = DLY_WIDTH_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dly;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          run;
  logic [AW-1:0] out_a;
  logic [BW-1:0] out_b;
  logic          out_stb;
  logic [15:0]   applied_count;
  logic          idle;

  stim_player dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dly        (in_dly),
    .in_a          (in_a),
    .in_b          (in_b),
    .run           (run),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_stb       (out_stb),
    .applied_count (applied_count),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stb_times[$];

  // Reference model state.
  stim_rec_t   mq[$];
  bit          m_work;
  stim_rec_t   m_rec;
  int unsigned m_tick;
  int unsigned m_due;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  logic          m_stb;
  logic [15:0]   m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit ready_pre;
    stim_rec_t r;
    if (!reset_n) begin
      mq.delete();
      m_work = 0;
      m_tick = 0;
      m_due  = 0;
      m_a    = '0;
      m_b    = '0;
      m_stb  = 1'b0;
      m_cnt  = '0;
      return;
    end
    ready_pre = (mq.size() < DEPTH);
    m_stb = 1'b0;
    if (run) begin
      m_tick++;
      if (m_work && m_tick == m_due) begin
        m_a   = m_rec.a;
        m_b   = m_rec.b;
        m_stb = 1'b1;
        m_cnt = m_cnt + 16'd1;
        m_work = 0;
      end
      if (!m_work && mq.size() > 0) begin
        m_rec  = mq.pop_front();
        m_work = 1;
        m_due  = m_tick + 32'(m_rec.dly) + 1;
      end
    end
    if (in_valid && ready_pre) begin
      r.dly = in_dly;
      r.a   = in_a;
      r.b   = in_b;
      mq.push_back(r);
    end
  endtask

  // One clock edge: update model with the inputs the DUT sampled, then
  // compare every output shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (out_stb === 1'b1) stb_times.push_back(cyc);
    check("out_a", 32'(out_a), 32'(m_a));
    check("out_b", 32'(out_b), 32'(m_b));
    check("out_stb", 32'(out_stb), 32'(m_stb));
    check("applied_count", 32'(applied_count), 32'(m_cnt));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check("idle", 32'(idle), 32'(!m_work && mq.size() == 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic push_one(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [BW-1:0] b);
    bit r;
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_dly = d;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      r = in_ready;
      step();
      if (r) done = 1;
    end
    in_valid = 1'b0;
    check("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (idle === 1'b1) done = 1;
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int acc;
    int run_len;
    int max_run;
    bit seen;
    bit r;

    // Reset with garbage on the inputs.
    reset_n  = 1'b0;
    in_valid = 1'b1;
    run      = 1'b1;
    in_dly   = DW'($urandom);
    in_a     = AW'($urandom);
    in_b     = BW'($urandom);
    step();
    step();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    run      = 1'b1;

    // Single record {3,1,0}: strobe seen after the 5th edge following push.
    push_one(8'd3, 17'd1, 5'd0);
    n = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      n++;
      if (out_stb === 1'b1) seen = 1;
    end
    check("single_latency", 32'(n), 32'd5);
    check("single_a", 32'(out_a), 32'd1);
    check("single_b", 32'(out_b), 32'd0);
    step();
    check("single_idle", 32'(idle), 32'd1);

    // Ten interleaved a/b records with dly=9: applies 10 cycles apart.
    do_reset();
    stb_times.delete();
    for (int k = 1; k <= 5; k++) begin
      push_one(8'd9, AW'(k), 5'd0);
      push_one(8'd9, 17'd0, BW'(k));
    end
    wait_idle(300);
    check("ab_count", 32'(applied_count), 32'd10);
    check("ab_applies", 32'(stb_times.size()), 32'd10);
    for (int i = 1; i < stb_times.size(); i++)
      check("ab_spacing", 32'(stb_times[i] - stb_times[i-1]), 32'd10);

    // Frozen playback: exactly DEPTH records accepted, 5th waits.
    do_reset();
    run = 1'b0;
    in_valid = 1'b1;
    in_dly = '0;
    in_a = AW'($urandom);
    in_b = BW'($urandom);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      r = in_ready;
      step();
      if (r) begin
        acc++;
        in_a = AW'($urandom);
        in_b = BW'($urandom);
      end
    end
    check("fill_accepted", 32'(acc), 32'(DEPTH));
    check("fill_ready_low", 32'(in_ready), 32'd0);
    run = 1'b1;
    n = 0;
    seen = 0;
    stb_times.delete();
    for (int i = 0; i < 20 && !seen; i++) begin
      r = in_ready;
      step();
      n++;
      if (r) seen = 1;
    end
    in_valid = 1'b0;
    check("fifth_accept_edge", 32'(n), 32'd2);
    wait_idle(50);
    max_run = 0;
    run_len = 0;
    for (int i = 0; i < stb_times.size(); i++) begin
      if (i > 0 && stb_times[i] == stb_times[i-1] + 1) run_len++;
      else run_len = 1;
      if (run_len > max_run) max_run = run_len;
    end
    check("consecutive_stb", 32'(max_run >= 4), 32'd1);

    // Freeze mid-WAIT for 7 cycles: apply lands 7 cycles late.
    do_reset();
    push_one(8'd5, AW'($urandom), BW'($urandom));
    n = 0;
    for (int i = 0; i < 3; i++) begin step(); n++; end
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin step(); n++; end
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      n++;
      if (out_stb === 1'b1) seen = 1;
    end
    check("freeze_latency", 32'(n), 32'd14);

    // Reset mid-WAIT with records queued.
    do_reset();
    push_one(8'd20, AW'($urandom), BW'($urandom));
    push_one(8'd20, AW'($urandom), BW'($urandom));
    push_one(8'd20, AW'($urandom), BW'($urandom));
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midreset_idle", 32'(idle), 32'd1);
    check("midreset_a", 32'(out_a), 32'd0);
    stb_times.delete();
    for (int i = 0; i < 40; i++) step();
    check("midreset_no_stb", 32'(stb_times.size()), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      run      = ($urandom_range(0, 7) != 0);
      in_dly   = DW'($urandom_range(0, 3));
      in_a     = AW'($urandom);
      in_b     = BW'($urandom);
      step();
    end
    in_valid = 1'b0;
    run = 1'b1;
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
